// File: rtl/aes_round_key_stack_if.sv
// Bus bundle between the key-expansion/round controller (master) and the
// round-key LIFO (slave).
//   start, round_amount    : begin a capture, latch the final round index
//   wr_valid, wr_key       : forward-order key write, accepted while wr_ready
//   pop                    : consume the presented key
//   rd_key, rd_index       : presented key and its round index, valid with rd_valid
//   done                   : one-cycle pulse after key 0 is popped
//   error                  : sticky protocol-error flag
interface aes_round_key_stack_if #(
    parameter int unsigned KEY_W = 128
);
    logic             start;
    logic [3:0]       round_amount;
    logic             wr_valid;
    logic [KEY_W-1:0] wr_key;
    logic             wr_ready;
    logic             pop;
    logic [KEY_W-1:0] rd_key;
    logic [3:0]       rd_index;
    logic             rd_valid;
    logic             done;
    logic             error;

    modport master (
        output start, round_amount, wr_valid, wr_key, pop,
        input  wr_ready, rd_key, rd_index, rd_valid, done, error
    );

    modport slave (
        input  start, round_amount, wr_valid, wr_key, pop,
        output wr_ready, rd_key, rd_index, rd_valid, done, error
    );
endinterface

// File: rtl/aes_round_key_stack.sv
// LIFO for AES round keys: captures keys 0..N in forward order during
// decryption key generation, then presents them N..0, one per pop.
// N = 10/12/14 for AES-128/192/256.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : aes_round_key_stack_if slave modport (see interface header)
module aes_round_key_stack #(
    parameter int unsigned KEY_W = 128,
    parameter int unsigned DEPTH = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    aes_round_key_stack_if.slave   bus
);
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ra_q, ra_d;
    logic [IDX_W-1:0]  wcnt_q, wcnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              wr_ready_q, rd_valid_q;
    logic              mem_we_c;
    logic              ra_legal_c;
    logic [IDX_W-1:0]  ptr_m1_c;

    logic [KEY_W-1:0]  mem [DEPTH];

    assign ra_legal_c = (bus.round_amount == IDX_W'(10)) ||
                        (bus.round_amount == IDX_W'(12)) ||
                        (bus.round_amount == IDX_W'(14));
    assign ptr_m1_c   = IDX_W'(ptr_q - IDX_W'(1));

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ra_q       <= '0;
            wcnt_q     <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
            key_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ra_q       <= ra_d;
            wcnt_q     <= wcnt_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            key_q      <= key_d;
            done_q     <= done_d;
            error_q    <= error_d;
            wr_ready_q <= (state_d == S_FILL);
            rd_valid_q <= (state_d == S_DRAIN);
        end
    end

    // Key storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[wcnt_q] <= bus.wr_key;
        end
    end

    // Next-state and datapath control; start overrides wr_valid/pop
    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        wcnt_d   = wcnt_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        key_d    = key_q;
        done_d   = 1'b0;
        error_d  = error_q;
        mem_we_c = 1'b0;

        if (bus.start) begin
            if (ra_legal_c) begin
                state_d = S_FILL;
                ra_d    = bus.round_amount;
                wcnt_d  = '0;
                error_d = 1'b0;
            end else begin
                state_d = S_IDLE;
                error_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.wr_valid || bus.pop) begin
                        error_d = 1'b1;
                    end
                end
                S_FILL: begin
                    if (bus.pop) begin
                        error_d = 1'b1;
                    end
                    if (bus.wr_valid) begin
                        mem_we_c = 1'b1;
                        wcnt_d   = IDX_W'(wcnt_q + IDX_W'(1));
                        // Last key bypasses the memory straight to the output
                        if (wcnt_q == ra_q) begin
                            state_d = S_DRAIN;
                            ptr_d   = ra_q;
                            key_d   = bus.wr_key;
                            idx_d   = ra_q;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.wr_valid) begin
                        error_d = 1'b1;
                    end
                    if (bus.pop) begin
                        if (ptr_q != '0) begin
                            ptr_d = ptr_m1_c;
                            key_d = mem[ptr_m1_c];
                            idx_d = ptr_m1_c;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_key   = key_q;
    assign bus.rd_index = idx_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_aes_round_key_stack.sv
module tb_aes_round_key_stack;
    localparam int unsigned KEY_W = 128;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    aes_round_key_stack_if #(.KEY_W(KEY_W)) bus ();

    aes_round_key_stack #(.KEY_W(KEY_W), .DEPTH(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Key i of a capture with byte base b: every byte equals b+i
    function automatic logic [127:0] kf(input logic [7:0] b, input int i);
        return {16{8'(int'(b) + i)}};
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int ra);
        bus.start        = 1'b1;
        bus.round_amount = 4'(ra);
        step();
        bus.start        = 1'b0;
    endtask

    // Write keys 0..ra; optional random gaps; optional illegal pop before write pop_at
    task automatic fill(input logic [7:0] b, input int ra, input bit gaps, input int pop_at);
        for (int i = 0; i <= ra; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    check("fill_gap_ready", 128'(bus.wr_ready), 128'(1));
                end
            end
            if (i == pop_at) begin
                bus.pop = 1'b1;
                step();
                bus.pop = 1'b0;
                check("pop_in_fill_err", 128'(bus.error), 128'(1));
                check("pop_in_fill_ready", 128'(bus.wr_ready), 128'(1));
                check("pop_in_fill_rdv", 128'(bus.rd_valid), 128'(0));
            end
            bus.wr_valid = 1'b1;
            bus.wr_key   = kf(b, i);
            step();
            bus.wr_valid = 1'b0;
            if (i < ra) begin
                check("fill_ready", 128'(bus.wr_ready), 128'(1));
            end else begin
                check("fill_last_ready", 128'(bus.wr_ready), 128'(0));
                check("fill_last_rdv", 128'(bus.rd_valid), 128'(1));
            end
        end
    endtask

    // Pop npops keys starting from presented index top; final pop expects done
    task automatic drain(input logic [7:0] b, input int top, input int npops, input bit gaps);
        int cur;
        cur = top;
        check("drain_rdv", 128'(bus.rd_valid), 128'(1));
        check("drain_idx", 128'(bus.rd_index), 128'(top));
        check("drain_key", bus.rd_key, kf(b, top));
        for (int k = 0; k < npops; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    check("drain_hold", bus.rd_key, kf(b, cur));
                end
            end
            bus.pop = 1'b1;
            step();
            bus.pop = 1'b0;
            if (cur > 0) begin
                cur--;
                check("pop_idx", 128'(bus.rd_index), 128'(cur));
                check("pop_key", bus.rd_key, kf(b, cur));
                check("pop_rdv", 128'(bus.rd_valid), 128'(1));
                check("pop_nodone", 128'(bus.done), 128'(0));
            end else begin
                check("last_rdv", 128'(bus.rd_valid), 128'(0));
                check("last_done", 128'(bus.done), 128'(1));
                check("last_key_hold", bus.rd_key, kf(b, 0));
                step();
                check("done_pulse", 128'(bus.done), 128'(0));
            end
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.round_amount = 4'd0;
        bus.wr_valid     = 1'b0;
        bus.wr_key       = '0;
        bus.pop          = 1'b0;
        step();
        step();
        check("rst_ready", 128'(bus.wr_ready), 128'(0));
        check("rst_rdv", 128'(bus.rd_valid), 128'(0));
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_err", 128'(bus.error), 128'(0));
        check("rst_key", bus.rd_key, 128'(0));
        check("rst_idx", 128'(bus.rd_index), 128'(0));
        reset = 1'b1;
        step();

        // AES-128, back-to-back writes and pops
        do_start(10);
        check("a128_ready", 128'(bus.wr_ready), 128'(1));
        fill(8'h00, 10, 1'b0, -1);
        check("a128_first_key", bus.rd_key, {16{8'h0A}});
        drain(8'h00, 10, 11, 1'b0);
        check("a128_last_key", bus.rd_key, 128'(0));
        check("a128_err", 128'(bus.error), 128'(0));

        // AES-256 with random gaps on both sides
        do_start(14);
        fill(8'h20, 14, 1'b1, -1);
        drain(8'h20, 14, 15, 1'b1);
        check("a256_err", 128'(bus.error), 128'(0));

        // Illegal mode, then a legal start clears the error
        do_start(11);
        check("ill_err", 128'(bus.error), 128'(1));
        check("ill_ready", 128'(bus.wr_ready), 128'(0));
        check("ill_rdv", 128'(bus.rd_valid), 128'(0));
        do_start(12);
        check("a192_err_clr", 128'(bus.error), 128'(0));
        check("a192_ready", 128'(bus.wr_ready), 128'(1));

        // AES-192 with a pop during FILL, then abort after 5 pops
        fill(8'h40, 12, 1'b0, 3);
        drain(8'h40, 12, 5, 1'b0);
        bus.start        = 1'b1;
        bus.round_amount = 4'd12;
        bus.pop          = 1'b1;
        step();
        bus.start        = 1'b0;
        bus.pop          = 1'b0;
        check("abort_ready", 128'(bus.wr_ready), 128'(1));
        check("abort_rdv", 128'(bus.rd_valid), 128'(0));
        check("abort_done", 128'(bus.done), 128'(0));
        check("abort_err", 128'(bus.error), 128'(0));

        // New capture after abort; a write during DRAIN must be dropped
        fill(8'h80, 12, 1'b0, -1);
        drain(8'h80, 12, 3, 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_key   = {16{8'hFF}};
        step();
        bus.wr_valid = 1'b0;
        check("wr_in_drain_err", 128'(bus.error), 128'(1));
        check("wr_in_drain_rdv", 128'(bus.rd_valid), 128'(1));
        check("wr_in_drain_idx", 128'(bus.rd_index), 128'(9));
        drain(8'h80, 9, 10, 1'b0);

        // Reset mid-FILL after 6 writes
        do_start(10);
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_key   = kf(8'h60, i);
            step();
        end
        bus.wr_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_ready", 128'(bus.wr_ready), 128'(0));
        check("arst_rdv", 128'(bus.rd_valid), 128'(0));
        check("arst_key", bus.rd_key, 128'(0));
        check("arst_idx", 128'(bus.rd_index), 128'(0));
        check("arst_err", 128'(bus.error), 128'(0));
        step();
        reset = 1'b1;
        repeat (3) begin
            step();
            check("post_rst_ready", 128'(bus.wr_ready), 128'(0));
            check("post_rst_done", 128'(bus.done), 128'(0));
        end
        do_start(10);
        fill(8'h50, 10, 1'b0, -1);
        drain(8'h50, 10, 11, 1'b0);
        check("final_err", 128'(bus.error), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
